adc_event_framer: RTL and testbench

- Parametrised multi-channel event framer between the ADC sample deserialisers and the SiTCP TCP transmit byte stream.
- Once armed, a beam trigger starts the capture. The block writes DEPTH consecutive sample frames (NCH channels each) into an internal buffer.
- It then sends a header followed by the payload to the TCP TX interface, one byte per cycle, and respects TCP_TX_FULL back-pressure.
- Adds channel, depth and width generality, auto re-arm, and missed-trigger accounting. The previous acquisition path had none of these.

---
 rtl/adc_framer_pkg.sv | 31 +++
 rtl/adc_event_framer_ram.sv | 30 +++
 rtl/adc_event_framer.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_adc_event_framer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_framer_pkg.sv
// Shared types and constants for the ADC event framer.
// Optional checksum trailer: ADC_EVENT_FRAMER_CHECKSUM_EN.
package adc_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HEADER  = 3'd3,
        ST_PAYLOAD = 3'd4
`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
        ,
        ST_TRAILER = 3'd5
`endif
    } state_t;

    localparam logic [7:0] MAGIC0 = 8'hA5;
    localparam logic [7:0] MAGIC1 = 8'h5A;

    localparam int HEADER_BYTES = 8;

    localparam int FLAG_MISSED = 7;
    localparam int FLAG_REARM  = 6;
    localparam int FLAG_CKSUM  = 5;

    // Pointer width that stays legal for a single-entry range.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_event_framer_ram.sv
// Simple dual-port sample buffer, one frame per word.
// Registered read: RdData follows RdAddr by one clock.
module adc_event_framer_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 224,
    parameter int AW    = 8
) (
    input  logic             CLK,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic [AW-1:0]    RdAddr,
    output logic [WIDTH-1:0] RdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store one captured frame.
    always_ff @(posedge CLK) begin
        if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
    end

    // Read port: one-cycle registered read.
    always_ff @(posedge CLK) begin
        RdData <= mem[RdAddr];
    end

endmodule

// File: rtl/adc_event_framer.sv
// Multi-channel ADC event framer feeding the SiTCP TX byte stream.
// Optional checksum trailer: ADC_EVENT_FRAMER_CHECKSUM_EN.
module adc_event_framer
    import adc_framer_pkg::*;
#(
    parameter int NCH         = 16,
    parameter int SAMPLE_W    = 14,
    parameter int DEPTH       = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    SampleValid,
    input  logic [NCH*SAMPLE_W-1:0] SampleData,
    input  logic                    Trigger,
    input  logic                    Arm,
    input  logic                    Abort,
    input  logic                    AutoRearm,
    input  logic                    TCP_TX_FULL,
    output logic                    TCP_TX_WR,
    output logic [7:0]              TCP_TX_DATA,
    output logic                    Busy,
    output logic                    Armed,
    output logic [15:0]             EventCount,
    output logic [7:0]              MissedTrig
);

    localparam int AW = ptrWidth(DEPTH);
    localparam int CW = ptrWidth(NCH);
    localparam int DW = NCH * SAMPLE_W;

    localparam logic [AW-1:0] LAST_FRAME = AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_CHAN  = CW'(NCH - 1);
    localparam logic [2:0]    LAST_HDR   = 3'(HEADER_BYTES - 1);
    localparam logic [15:0]   DEPTH16    = 16'(DEPTH);
    localparam logic [7:0]    NCH8       = 8'(NCH);

`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
    localparam logic CKSUM_ON = 1'b1;
`else
    localparam logic CKSUM_ON = 1'b0;
`endif

    state_t state;
    state_t nextState;
    state_t doneState;

    logic [SYNC_STAGES-1:0] trigSync;
    logic trigPrev;
    logic trigEdge;

    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdFrame;
    logic [AW-1:0] rdAddr;
    logic [CW-1:0] chan;
    logic          byteLo;
    logic [2:0]    hdrIdx;

    logic          ramWr;
    logic [DW-1:0] rdData;

    logic [15:0] sample16;
    logic [7:0]  flags;
    logic [7:0]  hdrByte;
    logic [7:0]  curByte;

    logic pending;
    logic lastByte;
    logic emit;
    logic stateDone;
    logic complete;
    logic chanLast;
    logic frameLast;
    logic frameAdvance;

    logic       txWr;
    logic [7:0] txData;
    logic [15:0] eventCnt;
    logic [7:0]  missedCnt;

`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
    logic [7:0] xorAcc;
`endif

    // Trigger synchroniser chain plus edge-history flop.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            trigSync <= '0;
            trigPrev <= 1'b0;
        end else begin
            trigSync <= {trigSync[SYNC_STAGES-2:0], Trigger};
            trigPrev <= trigSync[SYNC_STAGES-1];
        end
    end

    assign trigEdge = trigSync[SYNC_STAGES-1] & ~trigPrev;

    assign ramWr = (state == ST_CAPTURE) & SampleValid & ~Abort;

    adc_event_framer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DW),
        .AW    (AW)
    ) uRam (
        .CLK    (CLK),
        .WrEn   (ramWr),
        .WrAddr (wrPtr),
        .WrData (SampleData),
        .RdAddr (rdAddr),
        .RdData (rdData)
    );

    assign chanLast  = (chan == LAST_CHAN);
    assign frameLast = (rdFrame == LAST_FRAME);
    assign sample16  = 16'(rdData[chan*SAMPLE_W +: SAMPLE_W]);

    // Header byte selection and flag packing.
    always_comb begin
        flags = 8'h00;
        flags[FLAG_MISSED] = |missedCnt;
        flags[FLAG_REARM]  = AutoRearm;
        flags[FLAG_CKSUM]  = CKSUM_ON;
        unique case (hdrIdx)
            3'd0:    hdrByte = MAGIC0;
            3'd1:    hdrByte = MAGIC1;
            3'd2:    hdrByte = eventCnt[15:8];
            3'd3:    hdrByte = eventCnt[7:0];
            3'd4:    hdrByte = DEPTH16[15:8];
            3'd5:    hdrByte = DEPTH16[7:0];
            3'd6:    hdrByte = NCH8;
            default: hdrByte = flags;
        endcase
    end

    // Pick the pending byte for the current transmit state.
    always_comb begin
        pending  = 1'b0;
        lastByte = 1'b0;
        curByte  = 8'h00;
        unique case (state)
            ST_HEADER: begin
                pending  = 1'b1;
                curByte  = hdrByte;
                lastByte = (hdrIdx == LAST_HDR);
            end
            ST_PAYLOAD: begin
                pending  = 1'b1;
                curByte  = byteLo ? sample16[7:0] : sample16[15:8];
                lastByte = byteLo & chanLast & frameLast;
            end
`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
            ST_TRAILER: begin
                pending  = 1'b1;
                curByte  = xorAcc;
                lastByte = 1'b1;
            end
`endif
            default: begin
                pending = 1'b0;
            end
        endcase
    end

    assign emit      = pending & ~TCP_TX_FULL & ~Abort;
    assign stateDone = emit & lastByte;
    assign doneState = AutoRearm ? ST_ARMED : ST_IDLE;

`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
    assign complete = (state == ST_TRAILER) & stateDone;
`else
    assign complete = (state == ST_PAYLOAD) & stateDone;
`endif

    assign frameAdvance = (state == ST_PAYLOAD) & emit & byteLo & chanLast;

    // Read address runs one frame ahead so payload has no bubbles.
    always_comb begin
        rdAddr = '0;
        if (state == ST_PAYLOAD) begin
            if (frameAdvance) begin
                rdAddr = frameLast ? '0 : rdFrame + AW'(1);
            end else begin
                rdAddr = rdFrame;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; Abort overrides everything.
    always_comb begin
        nextState = state;
        unique case (state)
            ST_IDLE: begin
                if (Arm) nextState = ST_ARMED;
            end
            ST_ARMED: begin
                if (trigEdge) nextState = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (SampleValid && wrPtr == LAST_FRAME) begin
                    nextState = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (stateDone) nextState = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
                if (stateDone) nextState = ST_TRAILER;
`else
                if (stateDone) nextState = doneState;
`endif
            end
`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
            ST_TRAILER: begin
                if (stateDone) nextState = doneState;
            end
`endif
            default: begin
                nextState = ST_IDLE;
            end
        endcase
        if (Abort) nextState = ST_IDLE;
    end

    // State-decoded status outputs.
    always_comb begin
        Armed = (state == ST_ARMED);
        Busy  = (state != ST_IDLE) && (state != ST_ARMED);
    end

    // Byte output register and the pointers it consumes.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            txWr    <= 1'b0;
            txData  <= 8'h00;
            wrPtr   <= '0;
            hdrIdx  <= 3'd0;
            rdFrame <= '0;
            chan    <= '0;
            byteLo  <= 1'b0;
        end else begin
            txWr <= emit;
            if (emit) begin
                txData <= curByte;
            end
            if (state != ST_CAPTURE) begin
                wrPtr <= '0;
            end else if (ramWr) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (state != ST_HEADER) begin
                hdrIdx <= 3'd0;
            end else if (emit) begin
                hdrIdx <= hdrIdx + 3'd1;
            end
            if (state != ST_PAYLOAD) begin
                rdFrame <= '0;
                chan    <= '0;
                byteLo  <= 1'b0;
            end else if (emit) begin
                byteLo <= ~byteLo;
                if (byteLo) begin
                    chan <= chanLast ? '0 : chan + CW'(1);
                end
                if (frameAdvance) begin
                    rdFrame <= rdAddr;
                end
            end
        end
    end

    // Event and missed-trigger accounting.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            eventCnt  <= 16'h0000;
            missedCnt <= 8'h00;
        end else begin
            if (complete) begin
                eventCnt <= eventCnt + 16'd1;
            end
            if (trigEdge && state != ST_ARMED && missedCnt != 8'hFF) begin
                missedCnt <= missedCnt + 8'd1;
            end
        end
    end

`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
    // Running XOR over header and payload bytes of the packet.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            xorAcc <= 8'h00;
        end else if (state == ST_CAPTURE) begin
            xorAcc <= 8'h00;
        end else if (emit && state != ST_TRAILER) begin
            xorAcc <= xorAcc ^ curByte;
        end
    end
`endif

    assign TCP_TX_WR   = txWr;
    assign TCP_TX_DATA = txData;
    assign EventCount  = eventCnt;
    assign MissedTrig  = missedCnt;

endmodule

// File: tb/tb_adc_event_framer.sv
// Scoreboard bench for adc_event_framer (NCH=2, SAMPLE_W=14, DEPTH=4).
// Honours ADC_EVENT_FRAMER_CHECKSUM_EN when defined for the build.
module tb_adc_event_framer;

    localparam int NCH = 2;
    localparam int SW  = 14;
    localparam int DEP = 4;

`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
    localparam logic [7:0] CK_FLAG = 8'h20;
`else
    localparam logic [7:0] CK_FLAG = 8'h00;
`endif

    logic CLK = 1'b0;
    logic RESETn;
    logic SampleValid;
    logic [NCH*SW-1:0] SampleData;
    logic Trigger;
    logic Arm;
    logic Abort;
    logic AutoRearm;
    logic TCP_TX_FULL;
    logic TCP_TX_WR;
    logic [7:0] TCP_TX_DATA;
    logic Busy;
    logic Armed;
    logic [15:0] EventCount;
    logic [7:0] MissedTrig;

    int total = 0;
    int bad = 0;
    logic [7:0] expQ[$];
    bit throttle = 0;
    logic fullAtEdge = 1'b0;
    int expEvents = 0;

    logic [7:0] golden [24] = '{
        8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h04, 8'h02, CK_FLAG,
        8'h00, 8'h01, 8'h3F, 8'hFF,
        8'h00, 8'h02, 8'h3F, 8'hFF,
        8'h00, 8'h03, 8'h3F, 8'hFF,
        8'h00, 8'h04, 8'h3F, 8'hFF
    };

    adc_event_framer #(
        .NCH         (NCH),
        .SAMPLE_W    (SW),
        .DEPTH       (DEP),
        .SYNC_STAGES (2)
    ) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .SampleValid (SampleValid),
        .SampleData  (SampleData),
        .Trigger     (Trigger),
        .Arm         (Arm),
        .Abort       (Abort),
        .AutoRearm   (AutoRearm),
        .TCP_TX_FULL (TCP_TX_FULL),
        .TCP_TX_WR   (TCP_TX_WR),
        .TCP_TX_DATA (TCP_TX_DATA),
        .Busy        (Busy),
        .Armed       (Armed),
        .EventCount  (EventCount),
        .MissedTrig  (MissedTrig)
    );

    always #5 CLK = ~CLK;

    // FULL as seen by the DUT at each rising edge.
    always @(posedge CLK) fullAtEdge <= TCP_TX_FULL;

    // Back-pressure driver, changes only on falling edges.
    always @(negedge CLK) begin
        if (throttle) TCP_TX_FULL = 1'($urandom_range(0, 1));
        else          TCP_TX_FULL = 1'b0;
    end

    // Monitor: every written byte is popped and compared.
    always @(negedge CLK) begin
        logic [7:0] e;
        if (RESETn && TCP_TX_WR) begin
            total++;
            if (fullAtEdge) begin
                bad++;
                $display("FAIL wr_while_full got WR=1 want WR=0");
            end
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("FAIL extra_byte got=%02h want=none", TCP_TX_DATA);
            end else begin
                e = expQ.pop_front();
                if (TCP_TX_DATA !== e) begin
                    bad++;
                    $display("FAIL tx_byte got=%02h want=%02h", TCP_TX_DATA, e);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic pushBytes(input logic [7:0] b[$]);
        logic [7:0] x;
        x = 8'h00;
        foreach (b[i]) begin
            expQ.push_back(b[i]);
            x = x ^ b[i];
        end
`ifdef ADC_EVENT_FRAMER_CHECKSUM_EN
        expQ.push_back(x);
`endif
    endtask

    task automatic pushGolden();
        logic [7:0] b[$];
        foreach (golden[i]) b.push_back(golden[i]);
        pushBytes(b);
    endtask

    task automatic pushPkt(input logic [15:0] ev, input logic [13:0] base,
                           input logic [13:0] c1, input bit missed,
                           input bit rearm);
        logic [7:0] b[$];
        logic [15:0] s;
        b.push_back(8'hA5);
        b.push_back(8'h5A);
        b.push_back(ev[15:8]);
        b.push_back(ev[7:0]);
        b.push_back(8'h00);
        b.push_back(8'h04);
        b.push_back(8'h02);
        b.push_back({missed, rearm, 6'b0} | CK_FLAG);
        for (int i = 0; i < DEP; i++) begin
            s = {2'b00, base + 14'(i)};
            b.push_back(s[15:8]);
            b.push_back(s[7:0]);
            s = {2'b00, c1};
            b.push_back(s[15:8]);
            b.push_back(s[7:0]);
        end
        pushBytes(b);
    endtask

    task automatic pulseArm();
        @(negedge CLK) Arm = 1'b1;
        @(negedge CLK) Arm = 1'b0;
    endtask

    task automatic pulseTrigger();
        @(negedge CLK) Trigger = 1'b1;
        repeat (4) @(negedge CLK);
        Trigger = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic waitBusy();
        int n;
        for (n = 0; n < 40 && !Busy; n++) @(negedge CLK);
        chk("busy_timeout", int'(Busy), 1);
    endtask

    task automatic feed(input logic [13:0] base, input logic [13:0] c1,
                        input int nFrames);
        for (int i = 0; i < nFrames; i++) begin
            SampleValid = 1'b1;
            SampleData  = {c1, base + 14'(i)};
            @(negedge CLK);
            if (i == 1) begin
                SampleValid = 1'b0;
                SampleData  = '1;
                @(negedge CLK);
            end
        end
        SampleValid = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        for (n = 0; n < 2000 && (expQ.size() != 0 || Busy || TCP_TX_WR); n++)
            @(negedge CLK);
        chk("packet_drained", expQ.size(), 0);
    endtask

    task automatic runEvent(input logic [13:0] base, input logic [13:0] c1);
        pulseTrigger();
        waitBusy();
        feed(base, c1, DEP);
        waitDone();
    endtask

    initial begin
        int n;
        RESETn = 1'b0;
        SampleValid = 1'b0;
        SampleData = '0;
        Trigger = 1'b0;
        Arm = 1'b0;
        Abort = 1'b0;
        AutoRearm = 1'b0;
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        chk("rst_wr", int'(TCP_TX_WR), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_armed", int'(Armed), 0);
        chk("rst_events", int'(EventCount), 0);
        chk("rst_missed", int'(MissedTrig), 0);

        // Basic event, hand-written byte table.
        pulseArm();
        chk("armed_after_arm", int'(Armed), 1);
        pushGolden();
        runEvent(14'h0001, 14'h3FFF);
        expEvents = 1;
        chk("events_basic", int'(EventCount), expEvents);
        chk("idle_after_basic", int'(Armed), 0);

        // Same data with random back-pressure.
        throttle = 1;
        pulseArm();
        pushPkt(16'd1, 14'h0001, 14'h3FFF, 1'b0, 1'b0);
        runEvent(14'h0001, 14'h3FFF);
        throttle = 0;
        expEvents = 2;
        chk("events_throttle", int'(EventCount), expEvents);

        // Auto re-arm over three events.
        AutoRearm = 1'b1;
        pulseArm();
        for (int k = 0; k < 3; k++) begin
            pushPkt(16'(expEvents), 14'(16'h0100 * (k + 1)),
                    14'(16'h1234 + k), 1'b0, 1'b1);
            runEvent(14'(16'h0100 * (k + 1)), 14'(16'h1234 + k));
            expEvents++;
            chk("rearm_armed", int'(Armed), 1);
            chk("rearm_events", int'(EventCount), expEvents);
        end
        AutoRearm = 1'b0;
        @(negedge CLK) Abort = 1'b1;
        @(negedge CLK) Abort = 1'b0;
        chk("abort_from_armed", int'(Armed), 0);

        // Missed triggers: one during payload, two in idle.
        pulseArm();
        pushPkt(16'(expEvents), 14'h0010, 14'h2000, 1'b0, 1'b0);
        pulseTrigger();
        waitBusy();
        feed(14'h0010, 14'h2000, DEP);
        for (n = 0; n < 200 && expQ.size() > 14; n++) @(negedge CLK);
        pulseTrigger();
        waitDone();
        expEvents++;
        pulseTrigger();
        pulseTrigger();
        chk("missed_count", int'(MissedTrig), 3);
        chk("events_missed", int'(EventCount), expEvents);
        pulseArm();
        pushPkt(16'(expEvents), 14'h0020, 14'h0005, 1'b1, 1'b0);
        runEvent(14'h0020, 14'h0005);
        expEvents++;
        chk("events_after_missed", int'(EventCount), expEvents);

        // Abort in the middle of the payload.
        pulseArm();
        pushPkt(16'(expEvents), 14'h0030, 14'h0006, 1'b1, 1'b0);
        pulseTrigger();
        waitBusy();
        feed(14'h0030, 14'h0006, DEP);
        for (n = 0; n < 200 && expQ.size() > 12; n++) @(negedge CLK);
        Abort = 1'b1;
        @(negedge CLK);
        Abort = 1'b0;
        chk("abort_wr", int'(TCP_TX_WR), 0);
        chk("abort_busy", int'(Busy), 0);
        chk("abort_armed", int'(Armed), 0);
        expQ.delete();
        repeat (3) @(negedge CLK);
        chk("abort_events", int'(EventCount), expEvents);

        // Reset in the middle of capture.
        pulseArm();
        pulseTrigger();
        waitBusy();
        feed(14'h0040, 14'h0007, 2);
        RESETn = 1'b0;
        #1;
        chk("reset_wr", int'(TCP_TX_WR), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_events", int'(EventCount), 0);
        chk("reset_missed", int'(MissedTrig), 0);
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset_no_wr", int'(TCP_TX_WR), 0);

        // Clean event after the reset.
        pulseArm();
        pushPkt(16'd0, 14'h0100, 14'h0AAA, 1'b0, 1'b0);
        runEvent(14'h0100, 14'h0AAA);
        chk("events_post_reset", int'(EventCount), 1);

        repeat (4) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
